// File: rtl/vir_key_debounce.sv
// Key debouncer: 2-flop synchronizer feeding a four-state qualify FSM.
// A level change commits only after T_STABLE consecutive agreeing samples.
module vir_key_debounce #(
    parameter logic [17:0] T_STABLE = 18'd160000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_sig,
    input  logic       bounce_clr,
    output logic       key_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       busy,
    output logic [7:0] bounce_cnt
);

    typedef enum logic [1:0] {
        IDLE_HIGH  = 2'd0,
        CHECK_LOW  = 2'd1,
        IDLE_LOW   = 2'd2,
        CHECK_HIGH = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [17:0] count, count_nxt;
    logic        sync_p0, sync_p1;
    logic        commit_press, commit_release, reject;
    logic        key_level_nxt, busy_nxt;
    logic [7:0]  bounce_cnt_nxt;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Synchronizer stage; idles high so reset looks like a released key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= in_sig;
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE_HIGH;
            count         <= 18'd0;
            key_level     <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            busy          <= 1'b0;
            bounce_cnt    <= 8'd0;
        end else begin
            state         <= state_nxt;
            count         <= count_nxt;
            key_level     <= key_level_nxt;
            press_pulse   <= commit_press;
            release_pulse <= commit_release;
            busy          <= busy_nxt;
            bounce_cnt    <= bounce_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        count_nxt      = count;
        commit_press   = 1'b0;
        commit_release = 1'b0;
        reject         = 1'b0;
        case (state)
            IDLE_HIGH: begin
                count_nxt = 18'd0;
                if (!sync_p1) state_nxt = CHECK_LOW;
            end
            CHECK_LOW: begin
                if (sync_p1) begin
                    state_nxt = IDLE_HIGH;
                    count_nxt = 18'd0;
                    reject    = 1'b1;
                end else if (count == T_STABLE - 18'd1) begin
                    state_nxt    = IDLE_LOW;
                    count_nxt    = 18'd0;
                    commit_press = 1'b1;
                end else begin
                    count_nxt = count + 18'd1;
                end
            end
            IDLE_LOW: begin
                count_nxt = 18'd0;
                if (sync_p1) state_nxt = CHECK_HIGH;
            end
            CHECK_HIGH: begin
                if (!sync_p1) begin
                    state_nxt = IDLE_LOW;
                    count_nxt = 18'd0;
                    reject    = 1'b1;
                end else if (count == T_STABLE - 18'd1) begin
                    state_nxt      = IDLE_HIGH;
                    count_nxt      = 18'd0;
                    commit_release = 1'b1;
                end else begin
                    count_nxt = count + 18'd1;
                end
            end
            default: begin
                state_nxt = IDLE_HIGH;
                count_nxt = 18'd0;
            end
        endcase
    end

    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        key_level_nxt = key_level;
        if (commit_press)
            key_level_nxt = 1'b0;
        else if (commit_release)
            key_level_nxt = 1'b1;
        busy_nxt = (state_nxt == CHECK_LOW) || (state_nxt == CHECK_HIGH);
        if (bounce_clr)
            bounce_cnt_nxt = 8'd0;
        else if (reject)
            bounce_cnt_nxt = sat_inc8(bounce_cnt);
        else
            bounce_cnt_nxt = bounce_cnt;
    end

endmodule

// File: tb/tb_vir_key_debounce.sv
// Randomized and directed bench for vir_key_debounce with a queue scoreboard
// fed by a run-length reference model of the debounce rules.
module tb_vir_key_debounce;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_sig;
    logic       bounce_clr;
    logic       key_level, press_pulse, release_pulse, busy;
    logic [7:0] bounce_cnt;

    vir_key_debounce #(.T_STABLE(18'd16)) dut (
        .clk(clk), .rst_n(rst_n), .in_sig(in_sig), .bounce_clr(bounce_clr),
        .key_level(key_level), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .busy(busy), .bounce_cnt(bounce_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int fails = 0;
    int press_seen = 0;
    int release_seen = 0;

    logic [11:0] expq[$];
    logic        dly[$];
    logic        m_level;
    int          m_run;
    int          m_bc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle at the falling edge and predict the state after the next rising edge.
    task automatic cycle(input logic in_v, input logic clr, input logic rst);
        logic s, prs, rel, rej;
        @(negedge clk);
        in_sig     = in_v;
        bounce_clr = clr;
        if (rst) begin
            rst_n   = 1'b0;
            m_level = 1'b1;
            m_run   = 0;
            m_bc    = 0;
            dly     = '{1'b1, 1'b1};
            expq.push_back({1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
        end else begin
            rst_n = 1'b1;
            s   = dly[0];
            prs = 1'b0;
            rel = 1'b0;
            rej = 1'b0;
            if (s != m_level) begin
                m_run++;
                if (m_run == T + 1) begin
                    m_level = s;
                    m_run   = 0;
                    prs     = !s;
                    rel     = s;
                end
            end else if (m_run > 0) begin
                m_run = 0;
                rej   = 1'b1;
            end
            if (clr) m_bc = 0;
            else if (rej && m_bc < 255) m_bc++;
            void'(dly.pop_front());
            dly.push_back(in_v);
            expq.push_back({m_level, prs, rel, (m_run > 0), 8'(m_bc)});
        end
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) cycle(v, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        logic [11:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("scoreboard", {key_level, press_pulse, release_pulse, busy, bounce_cnt}, e);
                if (press_pulse) press_seen++;
                if (release_pulse) release_seen++;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int p0, r0, len;
        logic lvl;
        in_sig = 1'b1; bounce_clr = 1'b0; rst_n = 1'b0;
        m_level = 1'b1; m_run = 0; m_bc = 0; dly = '{1'b1, 1'b1};

        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        wait_edge();
        chk("reset_key", key_level, 1);
        chk("reset_busy", busy, 0);
        chk("reset_pulses", {press_pulse, release_pulse}, 0);
        chk("reset_bcnt", bounce_cnt, 0);

        // Clean press: E0 is the first edge that samples the low level.
        for (int k = 0; k <= 18; k++) begin
            cycle(1'b0, 1'b0, 1'b0);
            wait_edge();
            if (k == 1) chk("press_busy_e1", busy, 0);
            if (k == 2) chk("press_busy_e2", busy, 1);
            if (k == 17) chk("press_early", {key_level, press_pulse}, 2'b10);
            if (k == 18) chk("press_e18", {key_level, press_pulse, busy}, 3'b010);
        end
        cycle(1'b0, 1'b0, 1'b0);
        wait_edge();
        chk("press_one_cycle", {key_level, press_pulse}, 2'b00);

        // Clean release.
        for (int k = 0; k <= 18; k++) begin
            cycle(1'b1, 1'b0, 1'b0);
            wait_edge();
            if (k == 17) chk("release_early", {key_level, release_pulse}, 2'b00);
            if (k == 18) chk("release_e18", {key_level, release_pulse, busy}, 3'b110);
        end
        hold(1'b1, 4);

        // Bouncy press: three short lows, then held low.
        p0 = press_seen;
        repeat (3) begin
            hold(1'b0, 4);
            hold(1'b1, 4);
        end
        for (int k = 0; k <= 19; k++) begin
            cycle(1'b0, 1'b0, 1'b0);
            wait_edge();
            if (k == 17) chk("bouncy_early", press_pulse, 0);
            if (k == 18) chk("bouncy_e18", press_pulse, 1);
        end
        chk("bouncy_bcnt", bounce_cnt, 3);
        chk("bouncy_one_press", press_seen - p0, 1);

        // Short high glitch while pressed is rejected.
        r0 = release_seen;
        hold(1'b1, 10);
        hold(1'b0, 14);
        wait_edge();
        chk("glitch_no_release", release_seen - r0, 0);
        chk("glitch_bcnt", bounce_cnt, 4);
        chk("glitch_key", key_level, 0);

        // Randomized runs of alternating levels with occasional clears.
        hold(1'b1, 20);
        lvl = 1'b0;
        for (int r = 0; r < 40; r++) begin
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++)
                cycle(lvl, ($urandom_range(0, 31) == 0), 1'b0);
            lvl = !lvl;
        end

        // Reset while qualifying a press at count 10.
        hold(1'b1, 22);
        p0 = press_seen;
        for (int k = 0; k <= 12; k++) begin
            cycle(1'b0, 1'b0, 1'b0);
            wait_edge();
            if (k == 12) chk("pre_reset_busy", busy, 1);
        end
        cycle(1'b0, 1'b0, 1'b1);
        wait_edge();
        chk("midreset_outputs", {key_level, busy, press_pulse}, 3'b100);
        cycle(1'b0, 1'b0, 1'b1);
        wait_edge();
        chk("midreset_no_press", press_seen - p0, 0);
        for (int k = 0; k <= 19; k++) begin
            cycle(1'b0, 1'b0, 1'b0);
            wait_edge();
            if (k == 17) chk("post_reset_early", press_pulse, 0);
            if (k == 18) chk("post_reset_e18", {key_level, press_pulse}, 2'b01);
        end

        // Saturation, then a clear landing on a reject edge.
        hold(1'b1, 22);
        repeat (300) begin
            hold(1'b0, 2);
            hold(1'b1, 2);
        end
        wait_edge();
        chk("sat_bcnt", bounce_cnt, 255);
        hold(1'b0, 2);
        hold(1'b1, 2);
        cycle(1'b1, 1'b1, 1'b0);
        wait_edge();
        chk("clear_wins", bounce_cnt, 0);
        hold(1'b1, 5);

        wait_edge();
        #1;
        chk("scoreboard_drained", expq.size(), 0);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/vir_key_debounce.md
VIR_KEY_DEBOUNCE -- requirements
Module: vir_key_debounce

Interface
REQ-001 The block SHALL expose parameter T_STABLE, default 18'd160000, defining the stable-input window in clk cycles (8 ms at 20 MHz); legal range 2..262143.
REQ-002 The block SHALL expose port clk, input, 1, system clock (20 MHz nominal).
REQ-003 The block SHALL expose port rst_n, input, 1, reset (asynchronous, active-low).
REQ-004 The block SHALL expose port in_sig, input, 1, raw bouncing key level, asynchronous to clk, idle high, pressed low.
REQ-005 The block SHALL expose port bounce_clr, input, 1, synchronous clear of bounce_cnt.
REQ-006 The block SHALL expose port key_level, output, 1, debounced key level, registered.
REQ-007 The block SHALL expose port press_pulse, output, 1, one-cycle strobe on a committed high-to-low transition.
REQ-008 The block SHALL expose port release_pulse, output, 1, one-cycle strobe on a committed low-to-high transition.
REQ-009 The block SHALL expose port busy, output, 1, high while a candidate transition is being qualified.
REQ-010 The block SHALL expose port bounce_cnt, output, 8, saturating count of rejected candidate transitions.

Function
REQ-011 in_sig SHALL pass through a 2-flop synchronizer (both flops reset to 1); "s" below denotes the second flop's output.
REQ-012 The FSM SHALL have four states: IDLE_HIGH, CHECK_LOW, IDLE_LOW, CHECK_HIGH.
REQ-013 IDLE_HIGH: if s==0, the FSM SHALL go to CHECK_LOW and load count with 0; otherwise it SHALL stay.
REQ-014 CHECK_LOW with s==0: if count==T_STABLE-1, the FSM SHALL go to IDLE_LOW, set key_level=0 and press_pulse=1; otherwise count SHALL increment.
REQ-015 CHECK_LOW with s==1: the FSM SHALL return to IDLE_HIGH, clear count and increment bounce_cnt.
REQ-016 IDLE_LOW, CHECK_HIGH: the behaviour SHALL mirror REQ-013..015 with levels inverted; the commit SHALL set key_level=1 and release_pulse=1.
REQ-017 count SHALL be 18 bits, SHALL be cleared in IDLE states, and SHALL never exceed T_STABLE-1.
REQ-018 Latency: for a clean in_sig edge first sampled at clk edge E0, key_level and the pulse SHALL update at edge E0+T_STABLE+2.
REQ-019 press_pulse and release_pulse SHALL each be high for exactly one cycle per commit, SHALL be registered, and SHALL never be high together.
REQ-020 busy SHALL be 1 exactly when the state is CHECK_LOW or CHECK_HIGH, registered alongside the state.
REQ-021 bounce_cnt SHALL saturate at 255.
REQ-022 bounce_clr SHALL set bounce_cnt to 0 on the next edge; if a reject occurs in the same cycle, clear SHALL win (result 0).
REQ-023 A level change on in_sig shorter than one clk period that is not captured by the synchronizer SHALL have no effect.
REQ-024 Unreachable state encodings SHALL recover to IDLE_HIGH on the next edge.

Reset
REQ-025 While rst_n==0, the block SHALL immediately force: state=IDLE_HIGH, count=0, synchronizer flops=1, key_level=1, press_pulse=0, release_pulse=0, busy=0, bounce_cnt=0.
REQ-026 A reset asserted mid-CHECK SHALL abort qualification with no pulse emitted.
REQ-027 After reset release, a low in_sig SHALL be qualified normally starting from IDLE_HIGH.

Verification (T_STABLE=16)
REQ-028 Reset: after reset, outputs SHALL read key_level=1, busy=0, pulses=0, bounce_cnt=0.
REQ-029 Clean press: in_sig 1->0 first sampled at E0 and held -> busy=1 from E2, key_level=0 and press_pulse=1 at E18 only, busy=0 at E18.
REQ-030 Bouncy press: three 4-cycle low glitches separated by 4-cycle highs, then held low -> bounce_cnt=3, exactly one press_pulse, at 18 cycles after the final fall.
REQ-031 Release: from pressed state, in_sig 0->1 held -> key_level=1 and release_pulse one cycle at E0+18; a 10-cycle high glitch alone -> no release_pulse, bounce_cnt+1.
REQ-032 Saturation and clear: 300 rejected glitches -> bounce_cnt=255; bounce_clr coincident with a reject -> bounce_cnt=0.
REQ-033 Reset mid-operation: rst_n pulsed low at count=10 in CHECK_LOW -> key_level=1, busy=0, no press_pulse; a subsequently held low -> press at E0+18.
